// File: rtl/tdm_demux4.sv
// Time-division demultiplexer: scans an upstream 4:1 mux through slots 0..3 and
// publishes the four sampled channels together once per frame with a FV pulse.
module tdm_demux4 #(
  parameter int DW    = 2,
  parameter int DWELL = 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          EN,
  input  logic [DW-1:0] Y,
  output logic [1:0]    S,
  output logic [DW-1:0] A,
  output logic [DW-1:0] B,
  output logic [DW-1:0] C,
  output logic [DW-1:0] D,
  output logic          FV,
  output logic          BUSY
);

  localparam int CW = (DWELL > 2) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    s_q, s_d;
  logic [DW-1:0] sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic          fv_q, fv_d;
  logic          busy_q, busy_d;
  logic          cap_s;

  assign cap_s = (cnt_q == CNT_LAST);

  // State, counter, shadow and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= {CW{1'b0}};
      s_q     <= 2'd0;
      sh0_q   <= {DW{1'b0}};
      sh1_q   <= {DW{1'b0}};
      sh2_q   <= {DW{1'b0}};
      a_q     <= {DW{1'b0}};
      b_q     <= {DW{1'b0}};
      c_q     <= {DW{1'b0}};
      d_q     <= {DW{1'b0}};
      fv_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      sh0_q   <= sh0_d;
      sh1_q   <= sh1_d;
      sh2_q   <= sh2_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      fv_q    <= fv_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic: frame completion on the S=3 capture edge wins over abort.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    sh0_d   = sh0_q;
    sh1_d   = sh1_q;
    sh2_d   = sh2_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    fv_d    = 1'b0;
    case (state_q)
      IDLE: begin
        s_d   = 2'd0;
        cnt_d = {CW{1'b0}};
        if (!EN) begin
          state_d = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (cap_s && (s_q == 2'd3)) begin
          a_d   = sh0_q;
          b_d   = sh1_q;
          c_d   = sh2_q;
          d_d   = Y;
          fv_d  = 1'b1;
          s_d   = 2'd0;
          cnt_d = {CW{1'b0}};
          if (EN) begin
            state_d = IDLE;
          end else begin
            state_d = SCAN;
          end
        end else if (EN) begin
          state_d = IDLE;
          s_d     = 2'd0;
          cnt_d   = {CW{1'b0}};
          sh0_d   = {DW{1'b0}};
          sh1_d   = {DW{1'b0}};
          sh2_d   = {DW{1'b0}};
        end else if (cap_s) begin
          case (s_q)
            2'd0:    sh0_d = Y;
            2'd1:    sh1_d = Y;
            2'd2:    sh2_d = Y;
            default: sh0_d = sh0_q;
          endcase
          s_d   = s_q + 2'd1;
          cnt_d = {CW{1'b0}};
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        s_d     = 2'd0;
        cnt_d   = {CW{1'b0}};
      end
    endcase
    busy_d = (state_d == SCAN);
  end

  assign S    = s_q;
  assign A    = a_q;
  assign B    = b_q;
  assign C    = c_q;
  assign D    = d_q;
  assign FV   = fv_q;
  assign BUSY = busy_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4: two instances (DWELL=1 and DWELL=3) driven by mux models,
// checked every cycle against a slot/time-position reference model.
module tb_tdm_demux4;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] y      [2];
  logic [1:0] s_o    [2];
  logic [1:0] a_o    [2];
  logic [1:0] b_o    [2];
  logic [1:0] c_o    [2];
  logic [1:0] d_o    [2];
  logic       fv_o   [2];
  logic       busy_o [2];

  logic [1:0] ch [2][4];

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  bit chk_en = 0;
  bit rec    = 0;
  int fv_st0[$];
  int fv_st1[$];

  int         dwl   [2];
  bit         m_run [2];
  bit         m_fv  [2];
  int         m_t   [2];
  logic [1:0] m_sh  [2][4];
  logic [1:0] m_out [2][4];

  tdm_demux4 #(.DW(2), .DWELL(1)) u_d1 (
    .CLK(clk), .RST(rst), .EN(en), .Y(y[0]), .S(s_o[0]),
    .A(a_o[0]), .B(b_o[0]), .C(c_o[0]), .D(d_o[0]), .FV(fv_o[0]), .BUSY(busy_o[0])
  );

  tdm_demux4 #(.DW(2), .DWELL(3)) u_d3 (
    .CLK(clk), .RST(rst), .EN(en), .Y(y[1]), .S(s_o[1]),
    .A(a_o[1]), .B(b_o[1]), .C(c_o[1]), .D(d_o[1]), .FV(fv_o[1]), .BUSY(busy_o[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Mux models: DWELL=3 instance sees garbage except on the last cycle of a slot.
  initial begin
    y[0] = 2'b00;
    y[1] = 2'b00;
    forever begin
      @(negedge clk);
      #1;
      y[0] = ch[0][s_o[0]];
      if (m_run[1] && ((m_t[1] % dwl[1]) == dwl[1] - 1)) y[1] = ch[1][s_o[1]];
      else y[1] = ~ch[1][s_o[1]];
    end
  end

  // Reference model: position in frame t, slot = t / DWELL.
  initial begin
    dwl[0] = 1;
    dwl[1] = 3;
    forever begin
      @(posedge clk);
      cyc++;
      for (int k = 0; k < 2; k++) begin
        int  slot;
        bit  last;
        m_fv[k] = 1'b0;
        if (rst) begin
          chk_en   = 1'b1;
          m_run[k] = 1'b0;
          m_t[k]   = 0;
          for (int j = 0; j < 4; j++) begin
            m_sh[k][j]  = 2'b00;
            m_out[k][j] = 2'b00;
          end
        end else if (!m_run[k]) begin
          if (!en) begin
            m_run[k] = 1'b1;
            m_t[k]   = 0;
          end
        end else begin
          slot = m_t[k] / dwl[k];
          last = ((m_t[k] % dwl[k]) == dwl[k] - 1);
          if (last && slot == 3) begin
            for (int j = 0; j < 3; j++) m_out[k][j] = m_sh[k][j];
            m_out[k][3] = y[k];
            m_fv[k]     = 1'b1;
            m_t[k]      = 0;
            if (en) m_run[k] = 1'b0;
          end else if (en) begin
            m_run[k] = 1'b0;
            m_t[k]   = 0;
            for (int j = 0; j < 4; j++) m_sh[k][j] = 2'b00;
          end else begin
            if (last) m_sh[k][slot] = y[k];
            m_t[k]++;
          end
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int k = 0; k < 2; k++) begin
          logic [1:0] es;
          es = m_run[k] ? 2'(m_t[k] / dwl[k]) : 2'd0;
          chk($sformatf("S[%0d]", k), 8'(s_o[k]), 8'(es));
          chk($sformatf("A[%0d]", k), 8'(a_o[k]), 8'(m_out[k][0]));
          chk($sformatf("B[%0d]", k), 8'(b_o[k]), 8'(m_out[k][1]));
          chk($sformatf("C[%0d]", k), 8'(c_o[k]), 8'(m_out[k][2]));
          chk($sformatf("D[%0d]", k), 8'(d_o[k]), 8'(m_out[k][3]));
          chk($sformatf("FV[%0d]", k), 8'(fv_o[k]), 8'(m_fv[k]));
          chk($sformatf("BUSY[%0d]", k), 8'(busy_o[k]), 8'(m_run[k]));
        end
      end
      if (rec && fv_o[0] === 1'b1) fv_st0.push_back(cyc);
      if (rec && fv_o[1] === 1'b1) fv_st1.push_back(cyc);
    end
  end

  task automatic wait_s0(input logic [1:0] v);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (s_o[0] !== v && n < 20);
    chk("wait_S0", 8'(s_o[0]), 8'(v));
  endtask

  task automatic set_ch(input logic [1:0] c0, input logic [1:0] c1,
                        input logic [1:0] c2, input logic [1:0] c3);
    for (int k = 0; k < 2; k++) begin
      ch[k][0] = c0;
      ch[k][1] = c1;
      ch[k][2] = c2;
      ch[k][3] = c3;
    end
  endtask

  initial begin
    int start;
    rst = 1'b1;
    en  = 1'b0;
    set_ch(2'b11, 2'b11, 2'b11, 2'b11);

    // Reset with EN=0 and Y=11, then hold reset one more cycle.
    repeat (2) @(negedge clk);
    for (int r = 0; r < 2; r++) begin
      chk("rst_S", 8'(s_o[0]), 8'd0);
      chk("rst_A", 8'(a_o[0]), 8'd0);
      chk("rst_D", 8'(d_o[1]), 8'd0);
      chk("rst_FV", 8'(fv_o[0]), 8'd0);
      chk("rst_BUSY", 8'(busy_o[1]), 8'd0);
      @(negedge clk);
    end

    // Steady scan with channels 01,10,11,00.
    set_ch(2'b01, 2'b10, 2'b11, 2'b00);
    fv_st0.delete();
    fv_st1.delete();
    rec   = 1'b1;
    start = cyc;
    rst   = 1'b0;
    repeat (30) @(negedge clk);
    rec = 1'b0;
    chk("fv1_count_ok", 8'(fv_st0.size() >= 2), 8'd1);
    chk("fv3_count_ok", 8'(fv_st1.size() >= 2), 8'd1);
    if (fv_st0.size() >= 2) begin
      chk("fv1_latency", 8'(fv_st0[0] - start), 8'd5);
      chk("fv1_period", 8'(fv_st0[1] - fv_st0[0]), 8'd4);
    end
    if (fv_st1.size() >= 2) begin
      chk("fv3_latency", 8'(fv_st1[0] - start), 8'd13);
      chk("fv3_period", 8'(fv_st1[1] - fv_st1[0]), 8'd12);
    end
    for (int k = 0; k < 2; k++) begin
      chk("lit_A", 8'(a_o[k]), 8'h1);
      chk("lit_B", 8'(b_o[k]), 8'h2);
      chk("lit_C", 8'(c_o[k]), 8'h3);
      chk("lit_D", 8'(d_o[k]), 8'h0);
    end

    // Abort right after the S=1 capture edge.
    wait_s0(2'd2);
    en = 1'b1;
    set_ch(2'b11, 2'b11, 2'b11, 2'b11);
    @(negedge clk);
    chk("abort_S", 8'(s_o[0]), 8'd0);
    chk("abort_BUSY", 8'(busy_o[0]), 8'd0);
    chk("abort_FV", 8'(fv_o[0]), 8'd0);
    chk("abort_A", 8'(a_o[0]), 8'h1);
    chk("abort_B", 8'(b_o[0]), 8'h2);
    chk("abort_C", 8'(c_o[0]), 8'h3);
    chk("abort_D", 8'(d_o[0]), 8'h0);

    // EN=1 sampled on the S=3 capture edge completes the frame.
    en = 1'b0;
    wait_s0(2'd3);
    en = 1'b1;
    @(negedge clk);
    chk("s3en_FV", 8'(fv_o[0]), 8'd1);
    chk("s3en_A", 8'(a_o[0]), 8'h3);
    chk("s3en_D", 8'(d_o[0]), 8'h3);
    @(negedge clk);
    chk("s3en_FV_off", 8'(fv_o[0]), 8'd0);
    chk("s3en_BUSY", 8'(busy_o[0]), 8'd0);
    chk("s3en_S", 8'(s_o[0]), 8'd0);

    // Reset while scanning at S=2, EN held low.
    en = 1'b0;
    wait_s0(2'd2);
    rst = 1'b1;
    @(negedge clk);
    chk("rscan_S", 8'(s_o[0]), 8'd0);
    chk("rscan_BUSY", 8'(busy_o[0]), 8'd0);
    chk("rscan_A", 8'(a_o[0]), 8'd0);
    chk("rscan_D3", 8'(d_o[1]), 8'd0);
    rst = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 199) == 0);
      if (en == 1'b0 && $urandom_range(0, 29) == 0) en = 1'b1;
      else if (en == 1'b1 && $urandom_range(0, 4) == 0) en = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        for (int k = 0; k < 2; k++)
          for (int j = 0; j < 4; j++) ch[k][j] = 2'($urandom_range(0, 3));
      end
    end
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Time-division demultiplexer that drives the select input of an upstream 4:1 two-bit multiplexer and collects the returned data into four parallel channels A–D.
- It steps the select through slots 0..3, samples the multiplexer output Y at the end of each slot, and publishes all four channels together once per frame, with a one-cycle frame-valid pulse.
- Enable follows the multiplexer's convention: EN is active-low.

Parameters:
- DW, 2, data width of Y and of each channel A–D.
- DWELL, 1, clock cycles spent in each slot. Must be ≥1. Y is sampled on the last cycle of the slot, so there are DWELL-1 settle cycles before the sample.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  reset, synchronous, active-high; highest priority.
- EN  input  1  active-low run enable; 0 = scan frames, 1 = stop.
- Y  input  DW  multiplexer output; returns the channel currently selected by S.
- S  output  2  registered slot select driven to the multiplexer's select input.
- A  output  DW  channel 0 (slot S=0), updated once per completed frame.
- B  output  DW  channel 1 (slot S=1).
- C  output  DW  channel 2 (slot S=2).
- D  output  DW  channel 3 (slot S=3).
- FV  output  1  frame-valid pulse; high for one cycle when A–D update.
- BUSY  output  1  high while in SCAN.

Behaviour:
- Reset (RST=1 at an edge): the following take effect on the next cycle.
  - State IDLE, S=0, A=B=C=D=0, FV=0, BUSY=0.
  - Dwell counter = 0; shadow registers SH0..SH2 = 0.
  - Reset overrides EN and any in-progress frame.
- State IDLE:
  - S held at 0, BUSY=0, FV=0.
  - EN=0 sampled → SCAN at the next edge, with dwell counter = 0 and S = 0.
- State SCAN:
  - BUSY=1.
  - The dwell counter counts 0..DWELL-1. The edge where the counter equals DWELL-1 is the capture edge for slot S. At that edge the counter returns to 0 and S advances S+1 (mod 4, so 3 wraps to 0).
  - Capture edge, S=0/1/2: Y is stored into SH0/SH1/SH2.
  - Capture edge, S=3 (frame completion):
    - A←SH0, B←SH1, C←SH2, D←Y, all updated in the same edge.
    - FV=1 for exactly the following cycle.
    - Then, if EN=1 at this edge → IDLE, S←0. If EN=0 → stay in SCAN, S←0.
  - Non-capture edges: only the dwell counter increments; S and Y are unchanged.
- Abort:
  - Applies when EN=1 is sampled in SCAN at any edge other than the S=3 capture edge.
  - Next state IDLE, S←0, dwell counter←0, shadows cleared.
  - A–D keep the last completed frame; no FV is produced.
  - An S=3 capture edge with EN=1 completes the frame (FV pulse) before entering IDLE.
- Latency (DWELL=1):
  - EN=0 sampled at edge k → SCAN.
  - Captures at edges k+1 (S=0), k+2, k+3, k+4 (S=3).
  - FV high in the cycle after edge k+4.
  - General case: FV follows edge k+4·DWELL; frame period is 4·DWELL cycles.
- Widths: A–D, SH*, and Y are DW bits, transferred without modification. The dwell counter is max(1, clog2(DWELL)) bits.
- FV never stays high for two consecutive cycles unless 4·DWELL = 1, which is impossible given DWELL ≥ 1.

Test Plan:
- Reset: RST=1 for 2 cycles with EN=0 and Y=2'b11 → S=0, A–D=0, FV=0, BUSY=0; hold RST and confirm no state change.
- Steady scan, DWELL=1:
  - Bench mux model with channels 01, 10, 11, 00 drives Y from S; EN=0 from edge 0.
  - S sequence 0,1,2,3,0 starting after edge 0.
  - After edge 4: FV=1, A=01, B=10, C=11, D=00.
  - FV then repeats every 4 cycles.
- Mid-frame abort:
  - After one full frame, change channels to 11, 11, 11, 11 and raise EN right after the S=1 capture edge.
  - Next edge: IDLE, S=0, BUSY=0, no FV, A–D still 01, 10, 11, 00.
- EN=1 on the S=3 capture edge → FV=1 for one cycle with the new frame, then IDLE with S=0 and BUSY=0.
- DWELL=3:
  - Y is forced to garbage (e.g. 10) during the first 2 cycles of each slot and is correct in the 3rd.
  - Required: captured A–D are correct and FV has a 12-cycle period.
- RST=1 while in SCAN with S=2 → next cycle IDLE, all outputs 0, even with EN=0.
